cdce_config_sequencer: RTL and testbench

//  Upstream feeder for the CDCE serial shifter: after power-up or on request, walks a

---
 rtl/cdce_pkg.sv | 24 ++
 rtl/cdce_cycle_counter.sv | 37 +++
 rtl/cdce_config_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cdce_config_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdce_pkg.sv
// Shared definitions for the CDCE configuration sequencer.
//   CDCE_WORD_WIDTH : width of one CDCE register word
//   cdce_state_e    : sequencer FSM state encoding
//   cdce_max        : elaboration-time helper for sizing the shared cycle counter
package cdce_pkg;

   localparam int CDCE_WORD_WIDTH = 20;

   typedef enum logic [2:0] {
      ST_POWERUP   = 3'd0,
      ST_IDLE      = 3'd1,
      ST_FETCH     = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5,
      ST_FINISH    = 3'd6,
      ST_ABORT     = 3'd7
   } cdce_state_e;

   function automatic int cdce_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cdce_cycle_counter.sv
// Cycle counter shared by the sequencer's power-up, fetch, gap and timeout timing.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : return count to zero (takes priority over en)
//   en           : advance count by one per cycle
//   term         : terminal count value
//   tc           : count has reached term (count saturates there)
module cdce_cycle_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic             tc
);

   logic [WIDTH-1:0] count_q, count_d;

   assign tc = (count_q == term);

   // Saturating at term keeps a state that lingers past its terminal count
   // from wrapping and seeing a second, spurious terminal.
   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && !tc)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end

endmodule

// File: rtl/cdce_config_sequencer.sv
// Walks an external register table and feeds each word to the CDCE serial shifter.
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : level request, sampled in IDLE only
//   rom_addr      : table address (synchronous ROM, data one cycle later on rom_data)
//   rom_data      : table word
//   ser_enable    : shifter enable, high while a sequence (or power-up wait) is active
//   ser_start     : shifter start_transaction, held until the shifter drops ser_done
//   ser_word      : word presented to the shifter, stable from ISSUE through WAIT_DONE
//   ser_done      : shifter transaction_done (high = idle/finished)
//   busy          : sequence in progress, including power-up wait
//   config_done   : sticky, last sequence sent every word
//   timeout_err   : sticky, last sequence aborted on timeout
//   word_index    : index of the word currently/last issued
module cdce_config_sequencer
   import cdce_pkg::*;
#(
   parameter int NUM_WORDS      = 9,
   parameter int ADDR_WIDTH     = 4,
   parameter int POWERUP_CYCLES = 50000,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   output logic [ADDR_WIDTH-1:0]      rom_addr,
   input  logic [CDCE_WORD_WIDTH-1:0] rom_data,
   output logic                       ser_enable,
   output logic                       ser_start,
   output logic [CDCE_WORD_WIDTH-1:0] ser_word,
   input  logic                       ser_done,
   output logic                       busy,
   output logic                       config_done,
   output logic                       timeout_err,
   output logic [ADDR_WIDTH-1:0]      word_index
);

   localparam int CNT_MAX = cdce_max(cdce_max(POWERUP_CYCLES, TIMEOUT_CYCLES),
                                     cdce_max(GAP_CYCLES, 2));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Terminal values are "cycles in state minus one": the counter clears on
   // state entry and the exit decision is made on the last cycle.
   localparam logic [CNT_W-1:0] PWR_TERM   = CNT_W'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] FETCH_TERM = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TMO_TERM   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

   localparam cdce_state_e RESET_STATE = (POWERUP_CYCLES == 0) ? ST_IDLE : ST_POWERUP;

   cdce_state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0]      index_q, index_d;
   logic [CDCE_WORD_WIDTH-1:0] ser_word_q, ser_word_d;
   logic                       ser_start_q, ser_start_d;
   logic                       busy_q, busy_d;
   logic                       config_done_q, config_done_d;
   logic                       timeout_err_q, timeout_err_d;

   logic             cnt_clr, cnt_en, cnt_tc;
   logic [CNT_W-1:0] cnt_term;

   // One counter serves every timed state; each entry restarts it from zero.
   assign cnt_clr = (state_d != state_q);
   assign cnt_en  = (state_q != ST_IDLE);

   always_comb begin
      case (state_q)
         ST_POWERUP: cnt_term = PWR_TERM;
         ST_FETCH:   cnt_term = FETCH_TERM;
         ST_GAP:     cnt_term = GAP_TERM;
         default:    cnt_term = TMO_TERM;
      endcase
   end

   cdce_cycle_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .term    (cnt_term),
      .tc      (cnt_tc)
   );

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      ser_word_d    = ser_word_q;
      ser_start_d   = ser_start_q;
      config_done_d = config_done_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         ST_POWERUP: begin
            if (cnt_tc) begin
               state_d = ST_FETCH;
               index_d = '0;
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_FETCH;
               index_d       = '0;
               config_done_d = 1'b0;
               timeout_err_d = 1'b0;
            end
         end
         // Cycle 0 presents the address, cycle 1 has the ROM data.
         ST_FETCH: begin
            if (cnt_tc) begin
               ser_word_d  = rom_data;
               ser_start_d = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         // ser_done low means the shifter has taken the word; an already-low
         // ser_done on the first cycle counts as the acknowledge.
         ST_ISSUE: begin
            if (!ser_done) begin
               ser_start_d = 1'b0;
               state_d     = ST_WAIT_DONE;
            end else if (cnt_tc) begin
               ser_start_d   = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_ABORT;
            end
         end
         ST_WAIT_DONE: begin
            if (ser_done) begin
               state_d = ST_GAP;
            end else if (cnt_tc) begin
               timeout_err_d = 1'b1;
               state_d       = ST_ABORT;
            end
         end
         ST_GAP: begin
            if (cnt_tc) begin
               if (index_q == LAST_IDX) begin
                  config_done_d = 1'b1;
                  state_d       = ST_FINISH;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         ST_ABORT:  state_d = ST_IDLE;
         default:   state_d = RESET_STATE;
      endcase

      // Enable and busy drop together as FINISH/ABORT is entered.
      busy_d = (state_d == ST_POWERUP) || (state_d == ST_FETCH) || (state_d == ST_ISSUE) ||
               (state_d == ST_WAIT_DONE) || (state_d == ST_GAP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RESET_STATE;
         index_q       <= '0;
         ser_word_q    <= '0;
         ser_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         config_done_q <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         ser_word_q    <= ser_word_d;
         ser_start_q   <= ser_start_d;
         busy_q        <= busy_d;
         config_done_q <= config_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign rom_addr    = index_q;
   assign word_index  = index_q;
   assign ser_word    = ser_word_q;
   assign ser_start   = ser_start_q;
   assign ser_enable  = busy_q;
   assign busy        = busy_q;
   assign config_done = config_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdce_config_sequencer.sv
// Bench for cdce_config_sequencer: behavioural shifter with randomised ack and
// shift lengths, 16-entry synchronous ROM holding 20'hA0000+i, and a monitor
// that logs every word handed to the shifter and checks inter-word spacing.
module tb_cdce_config_sequencer;

   localparam int NUM_WORDS      = 9;
   localparam int ADDR_WIDTH     = 4;
   localparam int POWERUP_CYCLES = 100;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 1024;

   logic                  clk;
   logic                  reset_n;
   logic                  start;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [19:0]           rom_data;
   logic                  ser_enable, ser_start, ser_done;
   logic [19:0]           ser_word;
   logic                  busy, config_done, timeout_err;
   logic [ADDR_WIDTH-1:0] word_index;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rel    = 0;

   int mode        = 0;   // 0 normal, 1 never acknowledges, 2 acknowledges then never finishes
   int ack_dly_max = 3;

   logic [19:0] words[$];
   int          last_done_rise = 0;
   logic [19:0] cur_word = '0;

   cdce_config_sequencer #(
      .NUM_WORDS(NUM_WORDS), .ADDR_WIDTH(ADDR_WIDTH), .POWERUP_CYCLES(POWERUP_CYCLES),
      .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .ser_enable(ser_enable), .ser_start(ser_start), .ser_word(ser_word), .ser_done(ser_done),
      .busy(busy), .config_done(config_done), .timeout_err(timeout_err), .word_index(word_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [19:0] rom [16];
   initial for (int i = 0; i < 16; i++) rom[i] = 20'hA0000 + 20'(i);
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Shifter model: accept on enable&start, drop done after a random ack delay,
   // hold it low for a random shift length, then raise it again.
   int m_ph, m_cnt;
   logic m_done;
   assign ser_done = m_done;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_done <= 1'b1; m_ph <= 0; m_cnt <= 0;
      end else begin
         case (m_ph)
            0: begin
               m_done <= 1'b1;
               if (ser_enable && ser_start && mode != 1) begin
                  m_cnt <= int'($urandom_range(ack_dly_max, 0));
                  m_ph  <= 1;
               end
            end
            1: if (m_cnt == 0) begin
                  m_done <= 1'b0;
                  m_ph   <= (mode == 2) ? 3 : 2;
                  m_cnt  <= int'($urandom_range(24, 18));
               end else m_cnt <= m_cnt - 1;
            2: if (m_cnt == 0) begin
                  m_done <= 1'b1; m_ph <= 0;
               end else m_cnt <= m_cnt - 1;
            default: if (mode != 2) begin
                  m_done <= 1'b1; m_ph <= 0;
               end
         endcase
      end
   end

   function automatic logic [19:0] exp_word(input int i);
      return 20'hA0000 + 20'(i % NUM_WORDS);
   endfunction

   // Monitor: every word hand-off is logged; a word after the first in a sequence
   // must start GAP_CYCLES + 1 (done sample) + 2 (fetch) cycles after done returned.
   task automatic monitor_loop();
      logic p_start = 1'b0, p_done = 1'b0;
      forever begin
         @(negedge clk);
         if (ser_start && !p_start) begin
            words.push_back(ser_word);
            cur_word = ser_word;
            checks++;
            if (ser_enable !== 1'b1) begin
               errors++; $display("FAIL enable_with_start: ser_enable=%0b required 1", ser_enable);
            end
            if (word_index != 0) begin
               checks++;
               if (cyc - last_done_rise != GAP_CYCLES + 3) begin
                  errors++;
                  $display("FAIL word_spacing: idx %0d spacing=%0d required %0d", word_index,
                           cyc - last_done_rise, GAP_CYCLES + 3);
               end
            end
         end
         if (ser_done && !p_done) begin
            last_done_rise = cyc;
            if (reset_n && ser_enable) begin
               checks++;
               if (ser_word !== cur_word) begin
                  errors++; $display("FAIL word_held: ser_word=%h required %h", ser_word, cur_word);
               end
            end
         end
         p_start = ser_start;
         p_done  = ser_done;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_config_done(input int limit);
      for (int k = 0; k < limit && config_done !== 1'b1; k++) @(negedge clk);
   endtask

   task automatic test_reset();
      start = 1'b0; mode = 0; ack_dly_max = 3;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, ser_enable, ser_start, config_done, timeout_err, rom_addr, word_index, ser_word} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b en=%b st=%b cd=%b te=%b addr=%h idx=%h word=%h required all 0",
                  busy, ser_enable, ser_start, config_done, timeout_err, rom_addr, word_index, ser_word);
      end
      words.delete();
      reset_n = 1'b1; rel = cyc;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL busy_cycle1: busy=%b required 1", busy);
      end
      for (int k = 0; k < 300 && ser_start !== 1'b1; k++) @(negedge clk);
      checks++;
      if (cyc - rel != POWERUP_CYCLES + 2) begin
         errors++; $display("FAIL first_start_cycle: cycle=%0d required %0d", cyc - rel, POWERUP_CYCLES + 2);
      end
      wait_config_done(2000);
      checks++;
      if (config_done !== 1'b1 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL powerup_done: config_done=%b timeout_err=%b required 1/0", config_done, timeout_err);
      end
      checks++;
      if (words.size() != NUM_WORDS) begin
         errors++; $display("FAIL powerup_count: words=%0d required %0d", words.size(), NUM_WORDS);
      end
      for (int i = 0; i < words.size(); i++) begin
         checks++;
         if (words[i] !== exp_word(i)) begin
            errors++; $display("FAIL powerup_word%0d: got %h required %h", i, words[i], exp_word(i));
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ser_enable !== 1'b0 || config_done !== 1'b1) begin
         errors++; $display("FAIL powerup_idle: busy=%b en=%b cd=%b required 0/0/1", busy, ser_enable, config_done);
      end
   endtask

   task automatic test_start_pulse();
      words.delete();
      pulse_start();
      checks++;
      if (config_done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL start_clears: config_done=%b busy=%b required 0/1", config_done, busy);
      end
      wait_config_done(2000);
      checks++;
      if (words.size() != NUM_WORDS || config_done !== 1'b1) begin
         errors++; $display("FAIL start_seq: words=%0d cd=%b required %0d/1", words.size(), config_done, NUM_WORDS);
      end
      for (int i = 0; i < words.size(); i++) begin
         checks++;
         if (words[i] !== exp_word(i)) begin
            errors++; $display("FAIL start_word%0d: got %h required %h", i, words[i], exp_word(i));
         end
      end
   endtask

   task automatic test_stuck_high();
      int a;
      mode = 1;
      pulse_start();
      for (int k = 0; k < 50 && ser_start !== 1'b1; k++) @(negedge clk);
      a = cyc;
      for (int k = 0; k < TIMEOUT_CYCLES + 100 && ser_start !== 1'b0; k++) @(negedge clk);
      checks++;
      if (cyc - a != TIMEOUT_CYCLES) begin
         errors++; $display("FAIL issue_timeout_len: ser_start high %0d required %0d", cyc - a, TIMEOUT_CYCLES);
      end
      checks++;
      if (timeout_err !== 1'b1 || ser_enable !== 1'b0) begin
         errors++; $display("FAIL issue_abort: timeout_err=%b en=%b required 1/0", timeout_err, ser_enable);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || config_done !== 1'b0 || timeout_err !== 1'b1) begin
         errors++; $display("FAIL issue_idle: busy=%b cd=%b te=%b required 0/0/1", busy, config_done, timeout_err);
      end
      mode = 0;
   endtask

   task automatic test_stuck_low();
      int f;
      mode = 2; ack_dly_max = 0;
      pulse_start();
      for (int k = 0; k < 100 && ser_done !== 1'b0; k++) @(negedge clk);
      f = cyc;
      for (int k = 0; k < TIMEOUT_CYCLES + 100 && timeout_err !== 1'b1; k++) @(negedge clk);
      checks++;
      if (cyc - f != TIMEOUT_CYCLES + 1) begin
         errors++; $display("FAIL wait_timeout_len: %0d cycles required %0d", cyc - f, TIMEOUT_CYCLES + 1);
      end
      checks++;
      if (ser_enable !== 1'b0 || ser_start !== 1'b0) begin
         errors++; $display("FAIL wait_abort: en=%b st=%b required 0/0", ser_enable, ser_start);
      end
      mode = 0; ack_dly_max = 3;
      repeat (3) @(negedge clk);
      words.delete();
      pulse_start();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL recover_clear: timeout_err=%b required 0", timeout_err);
      end
      wait_config_done(2000);
      checks++;
      if (words.size() != NUM_WORDS || config_done !== 1'b1 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL recover_seq: words=%0d cd=%b te=%b required %0d/1/0",
                            words.size(), config_done, timeout_err, NUM_WORDS);
      end
   endtask

   task automatic test_reset_mid();
      words.delete();
      pulse_start();
      for (int k = 0; k < 1000 && !(word_index == 4 && ser_done === 1'b0); k++) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, ser_enable, ser_start, config_done, timeout_err, rom_addr, word_index, ser_word} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: busy=%b en=%b st=%b cd=%b te=%b addr=%h idx=%h word=%h required all 0",
                  busy, ser_enable, ser_start, config_done, timeout_err, rom_addr, word_index, ser_word);
      end
      repeat (2) @(negedge clk);
      words.delete();
      reset_n = 1'b1; rel = cyc;
      for (int k = 0; k < 300 && ser_start !== 1'b1; k++) @(negedge clk);
      checks++;
      if (cyc - rel != POWERUP_CYCLES + 2 || word_index != 0 || ser_word !== exp_word(0)) begin
         errors++; $display("FAIL midreset_restart: cycle=%0d idx=%0d word=%h required %0d/0/%h",
                            cyc - rel, word_index, ser_word, POWERUP_CYCLES + 2, exp_word(0));
      end
      wait_config_done(2000);
      checks++;
      if (words.size() != NUM_WORDS || config_done !== 1'b1) begin
         errors++; $display("FAIL midreset_seq: words=%0d cd=%b required %0d/1", words.size(), config_done, NUM_WORDS);
      end
   endtask

   task automatic test_back_to_back();
      int   rises = 0;
      logic p_cd;
      words.delete();
      @(negedge clk);
      p_cd  = config_done;
      start = 1'b1;
      for (int k = 0; k < 3000 && rises < 2; k++) begin
         @(negedge clk);
         if (config_done && !p_cd) rises++;
         p_cd = config_done;
      end
      start = 1'b0;
      checks++;
      if (words.size() != 2 * NUM_WORDS) begin
         errors++; $display("FAIL b2b_count: words=%0d required %0d", words.size(), 2 * NUM_WORDS);
      end
      for (int i = 0; i < words.size(); i++) begin
         checks++;
         if (words[i] !== exp_word(i)) begin
            errors++; $display("FAIL b2b_word%0d: got %h required %h", i, words[i], exp_word(i));
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || config_done !== 1'b1) begin
         errors++; $display("FAIL b2b_idle: busy=%b cd=%b required 0/1", busy, config_done);
      end
   endtask

   initial begin
      start   = 1'b0;
      reset_n = 1'b1;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_start_pulse();
      test_stuck_high();
      test_stuck_low();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
